// File: rtl/bit_scan8_pkg.sv
// Shared types and constants for the 8-bit set-bit scanner.
package bit_scan8_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N-1:0]     vec_t;

  // Two-state controller encoding.
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StScan = 1'b1;

endpackage

// File: rtl/lsb_index8.sv
// Combinational lowest-set-bit finder: index, one-hot mask and single-bit flag.
module lsb_index8
  import bit_scan8_pkg::*;
(
  input  vec_t pend_i,
  output idx_t idx_o,
  output vec_t mask_o,
  output logic single_o
);

  always_comb begin
    idx_o = '0;
    // Walk downwards so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) begin
        idx_o = idx_t'(i);
      end
    end
  end

  assign mask_o   = pend_i & (~pend_i + vec_t'(1));
  assign single_o = (pend_i != '0) && ((pend_i & (pend_i - vec_t'(1))) == '0);

endmodule

// File: rtl/bit_scan8.sv
// Accepts an 8-bit flag vector and emits the index of each set bit, lowest first.
module bit_scan8
  import bit_scan8_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [IDX_W-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             O_LAST,
  output logic             NONE
);

  state_t state_q, state_d;
  vec_t   pend_q, pend_d;
  logic   none_q, none_d;

  idx_t lsb_idx;
  vec_t lsb_mask;
  logic lsb_single;

  lsb_index8 u_lsb (
    .pend_i   (pend_q),
    .idx_o    (lsb_idx),
    .mask_o   (lsb_mask),
    .single_o (lsb_single)
  );

  // All outputs derive from registered state only.
  assign I_READY = (state_q == StIdle);
  assign O_VALID = (state_q == StScan);
  assign O       = O_VALID ? lsb_idx : '0;
  assign O_LAST  = O_VALID & lsb_single;
  assign NONE    = none_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    none_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_VALID) begin
          if (I != '0) begin
            pend_d  = I;
            state_d = StScan;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      StScan: begin
        if (O_READY) begin
          pend_d = pend_q & ~lsb_mask;
          if (lsb_single) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = '0;
      end
    endcase
  end

  // Reset overrides any handshake sampled on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_bit_scan8.sv
// Scoreboard bench for bit_scan8: stimulus pushes expected indices, a monitor pops them.
module tb_bit_scan8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] I;
  logic       I_VALID;
  logic       I_READY;
  logic [2:0] O;
  logic       O_VALID;
  logic       O_READY;
  logic       O_LAST;
  logic       NONE;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   none_exp = 0;

  bit         hold_prev = 1'b0;
  logic [2:0] hold_o;
  logic       hold_last;

  bit_scan8 dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I       (I),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .O       (O),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O_LAST  (O_LAST),
    .NONE    (NONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected output sequence for a vector: ascending indices, last flag on the top one.
  task automatic push_vec(input logic [7:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) exp_q.push_back('{idx: 3'(i), last: (i == hi)});
    end
    if (v == 8'h00) none_exp++;
  endtask

  // Present v, wait (bounded) for I_READY, let the accept edge pass, then drop I_VALID.
  task automatic send(input logic [7:0] v);
    int n;
    I = v;
    I_VALID = 1'b1;
    n = 0;
    while (!I_READY && n < 50) begin
      tick();
      n++;
    end
    check("send_ready_timeout", int'(I_READY), 1);
    push_vec(v);
    tick();
    I_VALID = 1'b0;
  endtask

  // Monitor: pops on every output handshake, checks stability under backpressure.
  always @(negedge CLK) begin
    if (hold_prev && !RESET) begin
      check("hold_valid", int'(O_VALID), 1);
      check("hold_o", int'(O), int'(hold_o));
      check("hold_last", int'(O_LAST), int'(hold_last));
    end
    hold_prev = (O_VALID === 1'b1) && (O_READY === 1'b0) && (RESET === 1'b0);
    hold_o    = O;
    hold_last = O_LAST;
    if (O_VALID === 1'b1 && O_READY === 1'b1 && RESET === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'(O), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_o", int'(O), int'(e.idx));
        check("sb_last", int'(O_LAST), int'(e.last));
      end
    end
    if (NONE === 1'b1) begin
      if (none_exp == 0) check("unexpected_none", 1, 0);
      else begin
        total++;
        none_exp--;
      end
    end
  end

  initial begin
    RESET   = 1'b1;
    I       = 8'hFF;
    I_VALID = 1'b1;
    O_READY = 1'b0;

    // Reset with a competing vector present.
    tick();
    tick();
    RESET   = 1'b0;
    I_VALID = 1'b0;
    check("rst_o_valid", int'(O_VALID), 0);
    check("rst_i_ready", int'(I_READY), 1);
    check("rst_o", int'(O), 0);
    check("rst_none", int'(NONE), 0);
    check("rst_o_last", int'(O_LAST), 0);
    tick();
    check("rst_no_accept", int'(O_VALID), 0);

    // Scan order.
    O_READY = 1'b1;
    send(8'b1010_0100);
    check("scan_t1_valid", int'(O_VALID), 1);
    check("scan_t1_o", int'(O), 2);
    check("scan_t1_ready", int'(I_READY), 0);
    tick();
    check("scan_t2_o", int'(O), 5);
    check("scan_t2_last", int'(O_LAST), 0);
    tick();
    check("scan_t3_o", int'(O), 7);
    check("scan_t3_last", int'(O_LAST), 1);
    tick();
    check("scan_t4_ready", int'(I_READY), 1);
    check("scan_t4_valid", int'(O_VALID), 0);

    // Backpressure.
    O_READY = 1'b0;
    send(8'h81);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", int'(O_VALID), 1);
      check("bp_o", int'(O), 0);
      check("bp_last", int'(O_LAST), 0);
      tick();
    end
    O_READY = 1'b1;
    check("bp_c4_o", int'(O), 0);
    tick();
    check("bp_o7", int'(O), 7);
    check("bp_o7_last", int'(O_LAST), 1);
    tick();
    check("bp_done_ready", int'(I_READY), 1);

    // Zero vector, then back-to-back zeros.
    send(8'h00);
    check("zero_none", int'(NONE), 1);
    check("zero_valid", int'(O_VALID), 0);
    check("zero_ready", int'(I_READY), 1);
    tick();
    check("zero_none_drop", int'(NONE), 0);
    I = 8'h00;
    I_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push_vec(8'h00);
      tick();
      check("zero_b2b_none", int'(NONE), 1);
      check("zero_b2b_ready", int'(I_READY), 1);
    end
    I_VALID = 1'b0;
    tick();
    check("zero_b2b_end", int'(NONE), 0);

    // Full vector with a competing source held valid.
    I = 8'hFF;
    I_VALID = 1'b1;
    push_vec(8'hFF);
    tick();
    I = 8'h01;
    for (int c = 0; c < 8; c++) begin
      check("full_valid", int'(O_VALID), 1);
      check("full_o", int'(O), c);
      check("full_ready", int'(I_READY), 0);
      tick();
    end
    check("full_t9_ready", int'(I_READY), 1);
    check("full_t9_valid", int'(O_VALID), 0);
    push_vec(8'h01);
    tick();
    I_VALID = 1'b0;
    check("full_t10_o", int'(O), 0);
    check("full_t10_last", int'(O_LAST), 1);
    tick();

    // Mid-scan reset after index 2 is taken.
    send(8'hFF);
    tick();
    tick();
    check("mid_o2", int'(O), 2);
    tick();
    check("mid_o3", int'(O), 3);
    RESET   = 1'b1;
    O_READY = 1'b0;
    exp_q.delete();
    tick();
    RESET   = 1'b0;
    O_READY = 1'b1;
    check("mid_valid", int'(O_VALID), 0);
    check("mid_ready", int'(I_READY), 1);
    check("mid_last", int'(O_LAST), 0);
    check("mid_pend", int'(dut.pend_q), 0);
    send(8'h10);
    check("mid_new_o", int'(O), 4);
    check("mid_new_last", int'(O_LAST), 1);
    tick();
    check("mid_new_done", int'(O_VALID), 0);
    tick();

    check("sb_drained", exp_q.size(), 0);
    check("none_drained", none_exp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
